// File: rtl/max_pkg.sv
// Shared definitions for the streaming maximum reducer: FSM state encoding
// and the helper that yields the beat-counter saturation value.
package max_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // All-ones value of a w-bit counter (w in 1..32); the wrap at w=32 is intentional.
  function automatic logic [31:0] cnt_sat(input int unsigned w);
    cnt_sat = (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/max_cmp.sv
// Combinational strict greater-than compare of a against b, signed or
// unsigned according to SIGNED.
module max_cmp #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);

  if (SIGNED) begin : g_signed
    assign gt = $signed(a) > $signed(b);
  end else begin : g_unsigned
    assign gt = a > b;
  end

endmodule

// File: rtl/stream_max_reduce.sv
// Streaming maximum reducer: accumulates the peak of each valid/ready input
// frame and presents it, with the beat count, on a valid/ready output.
// Optional feature macro: ARGMAX_EN adds the out_idx port carrying the
// 0-based beat index of the maximum (saturating like the beat counter).
module stream_max_reduce
  import max_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int CNT_W  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [CNT_W-1:0] out_count
`ifdef ARGMAX_EN
  , output logic [CNT_W-1:0] out_idx
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] max_r;
  logic [CNT_W-1:0] cnt_r;
  logic             beat_s;
  logic             hs_s;
  logic             gt_s;
  logic             take_s;
`ifdef ARGMAX_EN
  logic [CNT_W-1:0] idx_r;
`endif

  // Handshake decodes come straight from the state register, so no input
  // ever reaches an output combinationally.
  assign in_ready  = (state_r == ST_ACCUM);
  assign out_valid = (state_r == ST_HOLD);
  assign out_max   = max_r;
  assign out_count = cnt_r;
`ifdef ARGMAX_EN
  assign out_idx   = idx_r;
`endif

  max_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp (
    .a  (in_data),
    .b  (max_r),
    .gt (gt_s)
  );

  // Beat acceptance, result handshake, and whether the incoming beat wins.
  always_comb begin
    beat_s = 1'b0;
    hs_s   = 1'b0;
    take_s = 1'b0;
    beat_s = in_valid & (state_r == ST_ACCUM);
    hs_s   = out_ready & (state_r == ST_HOLD);
    // An empty accumulator (no beats yet) loads the first sample unconditionally.
    take_s = (cnt_r == {CNT_W{1'b0}}) | gt_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: close the frame on its last beat, reopen on result handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_ACCUM: begin
        if (beat_s && in_last) begin
          state_next_s = ST_HOLD;
        end else begin
          state_next_s = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (hs_s) begin
          state_next_s = ST_ACCUM;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: state_next_s = ST_ACCUM;
    endcase
  end

  // Running max, saturating beat count and (optionally) argmax index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_r <= {WIDTH{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
`ifdef ARGMAX_EN
      idx_r <= {CNT_W{1'b0}};
`endif
    end else if (hs_s) begin
      max_r <= {WIDTH{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
`ifdef ARGMAX_EN
      idx_r <= {CNT_W{1'b0}};
`endif
    end else if (beat_s) begin
      if (take_s) begin
        max_r <= in_data;
`ifdef ARGMAX_EN
        // The pre-increment count is this beat's index, already clamped at saturation.
        idx_r <= cnt_r;
`endif
      end
      if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_stream_max_reduce.sv
// Self-checking bench: an unsigned and a signed instance share one input
// stream; expectations come from a frame-level reference model.
module tb_stream_max_reduce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_u, out_valid_u, in_ready_s, out_valid_s;
  logic [15:0] out_max_u, out_max_s;
  logic [7:0]  out_count_u, out_count_s;
`ifdef ARGMAX_EN
  logic [7:0]  out_idx_u, out_idx_s;
`endif

  int checks   = 0;
  int failures = 0;
  logic [15:0] frame_q[$];

  always #5 clk = ~clk;

  stream_max_reduce #(.WIDTH(16), .CNT_W(8), .SIGNED(1'b0)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_u),
    .out_ready(out_ready), .out_max(out_max_u), .out_count(out_count_u)
`ifdef ARGMAX_EN
    , .out_idx(out_idx_u)
`endif
  );

  stream_max_reduce #(.WIDTH(16), .CNT_W(8), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_max(out_max_s), .out_count(out_count_s)
`ifdef ARGMAX_EN
    , .out_idx(out_idx_s)
`endif
  );

  // ---------------- reference model ----------------
  function automatic int as_int(input logic [15:0] v, input bit sgn);
    if (sgn) return int'($signed(v));
    return int'({16'd0, v});
  endfunction

  function automatic int ref_best(input bit sgn);
    int best = as_int(frame_q[0], sgn);
    foreach (frame_q[i]) if (as_int(frame_q[i], sgn) > best) best = as_int(frame_q[i], sgn);
    return best;
  endfunction

  function automatic logic [15:0] ref_max(input bit sgn);
    int best = ref_best(sgn);
    foreach (frame_q[i]) if (as_int(frame_q[i], sgn) == best) return frame_q[i];
    return 16'd0;
  endfunction

  function automatic logic [7:0] ref_idx(input bit sgn);
    int best = ref_best(sgn);
    foreach (frame_q[i]) if (as_int(frame_q[i], sgn) == best) return (i > 255) ? 8'd255 : 8'(i);
    return 8'd0;
  endfunction

  function automatic logic [7:0] ref_count();
    return (frame_q.size() > 255) ? 8'd255 : 8'(frame_q.size());
  endfunction

  // ---------------- stimulus helpers ----------------
  // Entered and left at posedge+1; random idle gaps with junk data between beats.
  task automatic drive_frame(input string name);
    int k = 0;
    int guard = 0;
    bit acc;
    while (k < frame_q.size() && guard < 5000) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_last  = 1'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = frame_q[k];
        in_last  = (k == frame_q.size() - 1);
      end
      acc = in_valid && in_ready_u;
      @(posedge clk); #1;
      guard++;
      if (acc) k++;
    end
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_last  = 1'b0;
    checks++;
    if (k != frame_q.size()) begin
      failures++;
      $display("FAIL %s accept_timeout: got %0d beats accepted, expected %0d", name, k, frame_q.size());
    end
    checks++;
    if (out_valid_u !== 1'b1 || out_valid_s !== 1'b1) begin
      failures++;
      $display("FAIL %s latency: got out_valid %b/%b one cycle after last beat, expected 1/1", name, out_valid_u, out_valid_s);
    end
  endtask

  task automatic check_result(input string name);
    logic [15:0] eu, es;
    logic [7:0]  ec;
    int w = 0;
    eu = ref_max(1'b0);
    es = ref_max(1'b1);
    ec = ref_count();
    while (!(out_valid_u && out_valid_s) && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (out_valid_u !== 1'b1 || out_valid_s !== 1'b1) begin
      failures++;
      $display("FAIL %s out_valid_timeout: got %b/%b, expected 1/1", name, out_valid_u, out_valid_s);
    end
    checks++;
    if (out_max_u !== eu) begin
      failures++;
      $display("FAIL %s max_uns: got %h, expected %h", name, out_max_u, eu);
    end
    checks++;
    if (out_max_s !== es) begin
      failures++;
      $display("FAIL %s max_sgn: got %h, expected %h", name, out_max_s, es);
    end
    checks++;
    if (out_count_u !== ec || out_count_s !== ec) begin
      failures++;
      $display("FAIL %s count: got %0d/%0d, expected %0d", name, out_count_u, out_count_s, ec);
    end
`ifdef ARGMAX_EN
    checks++;
    if (out_idx_u !== ref_idx(1'b0) || out_idx_s !== ref_idx(1'b1)) begin
      failures++;
      $display("FAIL %s idx: got %0d/%0d, expected %0d/%0d", name, out_idx_u, out_idx_s, ref_idx(1'b0), ref_idx(1'b1));
    end
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid_u !== 1'b0 || out_valid_s !== 1'b0 || in_ready_u !== 1'b1 || in_ready_s !== 1'b1) begin
      failures++;
      $display("FAIL %s after_handshake: got valid %b/%b ready %b/%b, expected 0/0 1/1",
               name, out_valid_u, out_valid_s, in_ready_u, in_ready_s);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if (in_ready_u !== 1'b1 || out_valid_u !== 1'b0 || out_max_u !== 16'd0 || out_count_u !== 8'd0 ||
        in_ready_s !== 1'b1 || out_valid_s !== 1'b0 || out_max_s !== 16'd0 || out_count_s !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: got rdy %b valid %b max %h cnt %0d, expected 1 0 0000 0",
               in_ready_u, out_valid_u, out_max_u, out_count_u);
    end
  endtask

  task automatic test_directed();
    frame_q = '{16'd10, 16'd20};             drive_frame("f_10_20");  check_result("f_10_20");
    frame_q = '{16'd40, 16'd30};             drive_frame("f_40_30");  check_result("f_40_30");
    frame_q = '{16'd7, 16'd9, 16'd9, 16'd3}; drive_frame("ties");     check_result("ties");
    frame_q = '{16'hFFFF, 16'h0001};         drive_frame("signed");   check_result("signed");
    frame_q = '{16'h1234};                   drive_frame("single");   check_result("single");
  endtask

  task automatic test_hold();
    logic [15:0] eu, es;
    frame_q = '{16'd300, 16'd800, 16'd50};
    drive_frame("hold");
    eu = ref_max(1'b0);
    es = ref_max(1'b1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      in_last  = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid_u !== 1'b1 || in_ready_u !== 1'b0 || out_max_u !== eu || out_max_s !== es) begin
        failures++;
        $display("FAIL hold_stable: cycle %0d got valid %b ready %b max %h/%h, expected 1 0 %h/%h",
                 c, out_valid_u, in_ready_u, out_max_u, out_max_s, eu, es);
      end
    end
    in_valid = 1'b0;
    check_result("hold");
    frame_q = '{16'd5};
    drive_frame("after_hold");
    check_result("after_hold");
  endtask

  task automatic test_random();
    for (int f = 0; f < 10; f++) begin
      int len = $urandom_range(1, 12);
      frame_q = {};
      for (int i = 0; i < len; i++) begin
        if (f[0]) frame_q.push_back(16'($urandom_range(0, 7)));
        else      frame_q.push_back(16'($urandom));
      end
      drive_frame("random");
      check_result("random");
    end
  endtask

  task automatic test_saturation();
    frame_q = {};
    for (int i = 0; i < 300; i++) frame_q.push_back(16'($urandom_range(0, 1000)));
    frame_q[280] = 16'h7FFF;
    drive_frame("saturation");
    check_result("saturation");
  endtask

  task automatic test_midframe_reset();
    in_valid = 1'b1; in_data = 16'd100; in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 16'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_max_u !== 16'd0 || out_count_u !== 8'd0 || out_valid_u !== 1'b0 || in_ready_u !== 1'b1 ||
        out_max_s !== 16'd0 || out_count_s !== 8'd0) begin
      failures++;
      $display("FAIL midframe_reset: got max %h cnt %0d valid %b ready %b, expected 0000 0 0 1",
               out_max_u, out_count_u, out_valid_u, in_ready_u);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    frame_q = '{16'd3, 16'd4};
    drive_frame("post_reset");
    check_result("post_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_hold();
    test_random();
    test_saturation();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
